// File: rtl/debug_button_conditioner.sv
// Per-channel push-button conditioner: 2-flop sync, counter debounce, press/release
// strobes and hold-to-repeat fire pulses. The release strobe port is release_pulse.
module debug_button_conditioner #(
    parameter int NBTN            = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_WIDTH       = 26
) (
    input  logic            CLK100MHZ,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    input  logic [NBTN-1:0] repeat_en,
    output logic [NBTN-1:0] level,
    output logic [NBTN-1:0] press,
    output logic [NBTN-1:0] release_pulse,
    output logic [NBTN-1:0] fire
);

    localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_HOLD = 2'd1;
    localparam logic [1:0] ST_REPEAT    = 2'd2;

    for (genvar g = 0; g < NBTN; g++) begin : g_ch
        logic                 sync1;
        logic                 sync2;
        logic                 lvl;
        logic                 prs;
        logic                 rls;
        logic                 fir;
        logic [CNT_WIDTH-1:0] dcnt;
        logic [CNT_WIDTH-1:0] hcnt;
        logic [1:0]           state;
        logic                 accept;
        logic                 rise;
        logic                 fall;

        always_comb begin
            accept = (sync2 != lvl) && (dcnt == DB_LAST);
            rise   = accept && sync2;
            fall   = accept && !sync2;
        end

        always_ff @(posedge CLK100MHZ) begin
            if (reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rls   <= 1'b0;
                fir   <= 1'b0;
                dcnt  <= '0;
                hcnt  <= '0;
                state <= ST_IDLE;
            end else begin
                sync1 <= btn_raw[g];
                sync2 <= sync1;
                prs   <= rise;
                rls   <= fall;

                if (sync2 == lvl || accept) begin
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                if (accept) begin
                    lvl <= sync2;
                end

                // Release overrides any pending hold/repeat tick in the same edge.
                fir <= 1'b0;
                if (fall) begin
                    state <= ST_IDLE;
                    hcnt  <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state <= ST_WAIT_HOLD;
                                hcnt  <= '0;
                                fir   <= 1'b1;
                            end
                        end
                        ST_WAIT_HOLD: begin
                            if (hcnt == HOLD_LAST) begin
                                state <= ST_REPEAT;
                                hcnt  <= '0;
                                fir   <= repeat_en[g];
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (hcnt == REP_LAST) begin
                                hcnt <= '0;
                                fir  <= repeat_en[g];
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            hcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[g]         = lvl;
        assign press[g]         = prs;
        assign release_pulse[g] = rls;
        assign fire[g]          = fir;
    end

endmodule

// File: tb/tb_debug_button_conditioner.sv
// Directed bench for debug_button_conditioner with short debounce/hold/repeat periods.
module tb_debug_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] repeat_en;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] fire;

    always #5 clk = ~clk;

    debug_button_conditioner #(
        .NBTN           (4),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (5),
        .CNT_WIDTH      (8)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .repeat_en    (repeat_en),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .fire         (fire)
    );

    int total = 0;
    int bad   = 0;
    int cyc;
    int fire_log[16];
    int nfire;
    int rel_at;
    int press_cnt[4];
    int rel_cnt[4];
    int fire_cnt[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            fire_cnt[i]  = 0;
        end
        cyc    = 0;
        nfire  = 0;
        rel_at = 0;
    endtask

    // One clock: outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (press[i] === 1'b1)         press_cnt[i]++;
            if (release_pulse[i] === 1'b1) rel_cnt[i]++;
            if (fire[i] === 1'b1)          fire_cnt[i]++;
        end
        if (fire[3] === 1'b1 && nfire < 16) begin
            fire_log[nfire] = cyc;
            nfire++;
        end
        if (release_pulse[3] === 1'b1) rel_at = cyc;
    endtask

    // Hold channel 3; repeat_en[3] is 1 from the start when en_at==0, else set after step en_at.
    task automatic hold_ch3(input int en_at, input int rel_after, input int nsteps);
        clear_counts();
        repeat_en[3] = (en_at == 0);
        btn_raw[3]   = 1'b1;
        for (int s = 1; s <= nsteps; s++) begin
            step();
            if (s == en_at) repeat_en[3] = 1'b1;
            if (s == rel_after) btn_raw[3] = 1'b0;
        end
    endtask

    int exp_a[7] = '{6, 16, 21, 26, 31, 36, 41};
    int exp_c[6] = '{6, 21, 26, 31, 36, 41};
    int exp_d[3] = '{6, 16, 21};

    initial begin
        reset     = 1'b1;
        btn_raw   = 4'hF;
        repeat_en = 4'h0;
        clear_counts();
        repeat (3) step();
        check("rst_level", level, 4'h0);
        check("rst_press", press, 4'h0);
        check("rst_release", release_pulse, 4'h0);
        check("rst_fire", fire, 4'h0);
        btn_raw = 4'h0;
        repeat (2) step();
        reset = 1'b0;
        repeat (8) step();
        check("idle_level", level, 4'h0);

        // Clean press/release on channel 1
        clear_counts();
        btn_raw = 4'b0010;
        repeat (5) step();
        check("clean_press_early", press, 4'h0);
        check("clean_level_early", level, 4'h0);
        step();
        check("clean_level", level, 4'b0010);
        check("clean_press", press, 4'b0010);
        check("clean_fire", fire, 4'b0010);
        check("clean_no_release", release_pulse, 4'h0);
        step();
        check("clean_press_width", press, 4'h0);
        check("clean_fire_width", fire, 4'h0);
        btn_raw = 4'h0;
        repeat (5) step();
        check("clean_release_early", release_pulse, 4'h0);
        step();
        check("clean_release", release_pulse, 4'b0010);
        check("clean_level_low", level, 4'h0);
        repeat (5) step();
        check("clean_press_cnt", press_cnt[1], 1);
        check("clean_fire_cnt", fire_cnt[1], 1);
        check("clean_rel_cnt", rel_cnt[1], 1);

        // Bounce on channel 2
        clear_counts();
        btn_raw[2] = 1'b1; step();
        btn_raw[2] = 1'b0; step();
        btn_raw[2] = 1'b1; step();
        btn_raw[2] = 1'b0; step();
        btn_raw[2] = 1'b1;
        repeat (5) step();
        check("bounce_no_early_press", press_cnt[2], 0);
        step();
        check("bounce_press", press, 4'b0100);
        repeat (10) step();
        check("bounce_press_cnt", press_cnt[2], 1);
        check("bounce_fire_cnt", fire_cnt[2], 1);
        btn_raw[2] = 1'b0;
        repeat (8) step();
        check("bounce_rel_cnt", rel_cnt[2], 1);

        // Auto-repeat enabled throughout
        hold_ch3(0, 40, 55);
        check("rep_nfire", nfire, 7);
        for (int i = 0; i < 7; i++) check($sformatf("rep_fire%0d", i), fire_log[i], exp_a[i]);
        check("rep_rel_at", rel_at, 46);

        // Auto-repeat disabled
        hold_ch3(1000, 40, 55);
        check("norep_nfire", nfire, 1);
        check("norep_fire0", fire_log[0], 6);
        check("norep_rel_at", rel_at, 46);

        // Enable repeat while already in the repeat phase
        hold_ch3(18, 40, 55);
        check("lateen_nfire", nfire, 6);
        for (int i = 0; i < 6; i++) check($sformatf("lateen_fire%0d", i), fire_log[i], exp_c[i]);

        // Release at hold count 7
        hold_ch3(0, 7, 30);
        check("midrel_nfire", nfire, 1);
        check("midrel_fire0", fire_log[0], 6);
        check("midrel_rel_at", rel_at, 13);
        check("midrel_rel_cnt", rel_cnt[3], 1);

        // Fresh hold after mid-hold release; release collides with a repeat slot
        hold_ch3(0, 20, 35);
        check("rehold_nfire", nfire, 3);
        for (int i = 0; i < 3; i++) check($sformatf("rehold_fire%0d", i), fire_log[i], exp_d[i]);
        check("rehold_rel_at", rel_at, 26);

        // Reset during repeat with button held
        clear_counts();
        repeat_en = 4'b1000;
        btn_raw   = 4'b1000;
        repeat (18) step();
        check("rstrep_fires_before", fire_cnt[3], 2);
        reset = 1'b1;
        step();
        check("rstrep_level", level, 4'h0);
        check("rstrep_press", press, 4'h0);
        check("rstrep_release", release_pulse, 4'h0);
        check("rstrep_fire", fire, 4'h0);
        reset = 1'b0;
        clear_counts();
        repeat (5) step();
        check("rstrep_no_fire", fire_cnt[3], 0);
        check("rstrep_no_press", press_cnt[3], 0);
        step();
        check("rstrep_press_again", press, 4'b1000);
        check("rstrep_fire_again", fire, 4'b1000);
        btn_raw = 4'h0;
        repeat (10) step();

        // Simultaneous presses on channels 0 and 2
        clear_counts();
        repeat_en = 4'h0;
        btn_raw   = 4'b0101;
        repeat (5) step();
        check("simul_press_early", press, 4'h0);
        step();
        check("simul_press", press, 4'b0101);
        check("simul_fire", fire, 4'b0101);
        check("simul_level", level, 4'b0101);
        btn_raw = 4'h0;
        repeat (6) step();
        check("simul_release", release_pulse, 4'b0101);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
